// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command front-end.
//   DATA_W      : datapath operand/result width
//   OP_*        : datapath operation codes; for the two |x| codes bit 0 is a
//                 don't-care, so only the canonical value is given here
//   state_e     : sequencer state encoding
//   op_is_abs() : true for either absolute-value code (01x, 11x)
package calc_pkg;

  localparam int DATA_W = 4;

  localparam logic [2:0] OP_ADD_AB = 3'b000;
  localparam logic [2:0] OP_SUB_AB = 3'b001;
  localparam logic [2:0] OP_ABS_B  = 3'b010;
  localparam logic [2:0] OP_ADD_BA = 3'b100;
  localparam logic [2:0] OP_SUB_BA = 3'b101;
  localparam logic [2:0] OP_ABS_A  = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic logic op_is_abs(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/calc_sequencer.sv
// Command front-end for the 4-bit combinational calculator datapath.
// Accepts a command, holds operands on calc_* for SETTLE_CYCLES cycles,
// captures R/ovf and returns them over a valid/ready response channel.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// ISSUE | operands driven on calc_*, settle counter running down to 0
// RESP  | rsp_valid high, result held until rsp_ready
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op/cmd_a/cmd_b         command operation and operands
//   cmd_chain                  use accumulated previous result as A
//   calc_op/calc_a/calc_b      to datapath (held between commands)
//   calc_r/calc_ovf            from datapath
//   rsp_valid/rsp_ready        response handshake
//   rsp_r/rsp_ovf              captured result
//   sticky_ovf, clr_sticky     sticky overflow and its synchronous clear
//   op_count                   completed captures, wrapping
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,  // valid range 1..15
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_chain,
  output logic [2:0]        calc_op,
  output logic [DATA_W-1:0] calc_a,
  output logic [DATA_W-1:0] calc_b,
  input  logic [DATA_W-1:0] calc_r,
  input  logic              calc_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_r,
  output logic              rsp_ovf,
  output logic              sticky_ovf,
  input  logic              clr_sticky,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] rsp_r_q, rsp_r_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rsp_r_q   <= '0;
      rsp_ovf_q <= 1'b0;
      sticky_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rsp_r_q   <= rsp_r_d;
      rsp_ovf_q <= rsp_ovf_d;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rsp_r_d   = rsp_r_q;
    rsp_ovf_d = rsp_ovf_q;
    count_d   = count_q;
    capture   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_chain ? acc_q : cmd_a;
          b_d     = cmd_b;
          cnt_d   = SETTLE_LOAD;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == 4'd0) begin
          capture   = 1'b1;
          rsp_r_d   = calc_r;
          rsp_ovf_d = calc_ovf;
          acc_d     = calc_r;
          count_d   = count_q + CNT_W'(1);
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new overflow at the capture edge outranks a concurrent clear.
    sticky_d = clr_sticky ? 1'b0 : sticky_q;
    if (capture && calc_ovf) sticky_d = 1'b1;
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign calc_op    = op_q;
  assign calc_a     = a_q;
  assign calc_b     = b_q;
  assign rsp_r      = rsp_r_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign sticky_ovf = sticky_q;
  assign op_count   = count_q;

endmodule
